// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam int DW_DEFAULT   = 16;
    localparam int ACCW_DEFAULT = 32;

    // Linear address of element (major, minor) in an n-wide array.
    // A uses (row, k), B uses (col, k) since it is stored column-major, C uses (row, col).
    function automatic int unsigned lin_addr(input int unsigned major,
                                             input int unsigned minor,
                                             input int unsigned n);
        return major * n + minor;
    endfunction

endpackage

// File: rtl/matmul_mac_acc.sv
// Registered multiply-accumulate: acc <= acc + a*b when enabled; clr has priority.
// Latency: 1 cycle from en to updated acc.
// Backpressure: none; the caller gates en.
module matmul_mac_acc
    import matmul_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int ACCW = ACCW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic [ACCW-1:0] acc_o
);

    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] prod_acc;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;

    // Full-width product, resized to the accumulator width; the add wraps.
    always_comb begin
        prod     = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        prod_acc = ACCW'(prod);
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_acc;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_scheduler.sv
// Sequences C = A x B over one MAC lane, walking i (row), j (col), k (dot index).
// Latency: N+2 cycles per result with res_ready high; done at N*N*(N+2)+1 after start.
// Backpressure: res_ready low holds the FSM in WRITE with result stable and no reads issued.
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int N    = 128,
    parameter int DW   = DW_DEFAULT,
    parameter int ACCW = ACCW_DEFAULT,
    parameter int AW   = $clog2(N*N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   a_addr,
    output logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   a_rdata,
    input  logic [DW-1:0]   b_rdata,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [AW-1:0]   res_addr,
    output logic [ACCW-1:0] res_data
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N-1);

    state_e          state_q, state_d;
    logic [CW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic            rd_en_q;
    logic            done_q, done_d;
    logic            hs, last_elem, acc_clr;
    logic [ACCW-1:0] acc;

    assign hs        = (state_q == WRITE) && res_ready;
    assign last_elem = (i_q == LAST) && (j_q == LAST);

    // The accumulator restarts on a new job, after each non-final result, or on abort.
    assign acc_clr = abort || ((state_q == IDLE) && start) || (hs && !last_elem);
    assign done_d  = hs && last_elem && !abort;

    matmul_mac_acc #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (rd_en_q),
        .a_i   (a_rdata),
        .b_i   (b_rdata),
        .acc_o (acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, including a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (k_q == LAST) state_d = DRAIN;
                DRAIN:   state_d = WRITE;
                WRITE:   if (res_ready) state_d = last_elem ? IDLE : RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; addresses and result are zero outside their phases.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        a_addr    = '0;
        b_addr    = '0;
        res_addr  = '0;
        res_data  = '0;
        case (state_q)
            RUN: begin
                rd_en  = 1'b1;
                a_addr = AW'(lin_addr(32'(i_q), 32'(k_q), N));
                b_addr = AW'(lin_addr(32'(j_q), 32'(k_q), N));
            end
            WRITE: begin
                res_valid = 1'b1;
                res_addr  = AW'(lin_addr(32'(i_q), 32'(j_q), N));
                res_data  = acc;
            end
            default: ;
        endcase
    end

    // Index counters: k steps each RUN cycle, (i,j) advance on each non-final handshake.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (abort) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_d = '0;
                        j_d = '0;
                        k_d = '0;
                    end
                end
                RUN: k_d = (k_q == LAST) ? '0 : k_q + CW'(1);
                WRITE: begin
                    if (res_ready && !last_elem) begin
                        if (j_q == LAST) begin
                            j_d = '0;
                            i_d = i_q + CW'(1);
                        end else begin
                            j_d = j_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter, read-pipeline and done registers; abort drops any in-flight accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            rd_en_q <= rd_en && !abort;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Randomized self-checking bench for matmul_scheduler at N=4.
// Latency: checks result order, values, stalls, abort, reset and done timing.
// Backpressure: drives res_ready low for a window to exercise the WRITE stall.
module tb_matmul_scheduler;

    localparam int N        = 4;
    localparam int DW       = 16;
    localparam int ACCW     = 32;
    localparam int AW       = 4;
    localparam int NN       = N * N;
    localparam int JOB_DONE = NN * (N + 2) + 1;
    localparam int LIMIT    = 400;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            res_ready = 1'b1;
    logic            busy, done, rd_en, res_valid;
    logic [AW-1:0]   a_addr, b_addr, res_addr;
    logic [DW-1:0]   a_rdata, b_rdata;
    logic [ACCW-1:0] res_data;

    int unsigned     mat_a [N][N];
    int unsigned     mat_b [N][N];
    logic [DW-1:0]   a_mem [NN];
    logic [DW-1:0]   b_mem [NN];
    logic [ACCW-1:0] c_ref [NN];

    int n_checks = 0;
    int n_err    = 0;

    matmul_scheduler #(
        .N    (N),
        .DW   (DW),
        .ACCW (ACCW),
        .AW   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_rdata   (a_rdata),
        .b_rdata   (b_rdata),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_addr  (res_addr),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    // Operand RAMs: one-cycle read latency; garbage on idle cycles so ungated accumulates show up.
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= a_mem[a_addr];
            b_rdata <= b_mem[b_addr];
        end else begin
            a_rdata <= DW'($urandom);
            b_rdata <= DW'($urandom);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Build operand matrices, lay them out in RAM, and compute the reference product.
    task automatic load_mats(input int mode);
        longint unsigned s;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0: begin
                        mat_a[r][c] = (r == c) ? 1 : 0;
                        mat_b[r][c] = 4 * r + c;
                    end
                    1: begin
                        mat_a[r][c] = 32'hFFFF;
                        mat_b[r][c] = 32'hFFFF;
                    end
                    default: begin
                        mat_a[r][c] = $urandom_range(0, 65535);
                        mat_b[r][c] = $urandom_range(0, 65535);
                    end
                endcase
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_mem[r * N + c] = DW'(mat_a[r][c]);
                b_mem[c * N + r] = DW'(mat_b[r][c]);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    s += longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
                end
                c_ref[i * N + j] = ACCW'(s);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_rd_en"},     rd_en,     0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_a_addr"},    a_addr,    0);
        check({tag, "_b_addr"},    b_addr,    0);
        check({tag, "_res_addr"},  res_addr,  0);
        check({tag, "_res_data"},  res_data,  0);
    endtask

    // One job. stall_el: element whose result is held 5 cycles; *_cyc: cycle to pulse that input
    // (0 = never); exp_done: cycle at which done must appear (0 = untimed).
    task automatic run_job(input int stall_el, input int abort_cyc, input int restart_cyc,
                           input int rst_cyc, input int exp_done);
        int cyc, nres, stall_cnt, dones, kk, kill_cyc;
        bit killed, finished;
        nres = 0; stall_cnt = 0; dones = 0; kk = 0; kill_cyc = 0;
        killed = 0; finished = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        forever begin
            res_ready = !(nres == stall_el && stall_cnt < 5);
            abort     = (cyc == abort_cyc);
            start     = (cyc == restart_cyc);
            rst       = (cyc == rst_cyc);
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (cyc == abort_cyc) check("abort_in_run", rd_en, 1);
            if (cyc == rst_cyc) check("rst_in_write", res_valid, 1);
            if (killed && cyc == kill_cyc + 1) begin
                check("kill_busy",      busy,      0);
                check("kill_res_valid", res_valid, 0);
                check("kill_rd_en",     rd_en,     0);
                if (rst_cyc != 0) check_all_zero("rst_mid_job");
            end
            if (!killed && rd_en) begin
                check("a_addr", a_addr, (nres / N) * N + kk);
                check("b_addr", b_addr, (nres % N) * N + kk);
                kk = (kk + 1) % N;
            end
            if (!killed && res_valid && !res_ready) begin
                stall_cnt++;
                check("stall_rd_en", rd_en,    0);
                check("stall_addr",  res_addr, nres);
                check("stall_data",  res_data, c_ref[nres]);
            end
            if (!killed && res_valid && res_ready && !abort && !rst) begin
                check("res_addr", res_addr, nres);
                check("res_data", res_data, c_ref[nres]);
                nres++;
            end
            if (done) begin
                dones++;
                check("done_busy", busy, 0);
                if (exp_done != 0) check("done_cycle", cyc, exp_done);
            end
            if (!killed && (abort || rst)) begin
                killed   = 1;
                kill_cyc = cyc;
            end
            if (done && !killed) begin
                finished = 1;
                break;
            end
            if (killed && cyc >= kill_cyc + 4) begin
                finished = 1;
                break;
            end
            if (cyc >= LIMIT) break;
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b0; start = 1'b0; rst = 1'b0; res_ready = 1'b1;
        check("job_terminated", finished, 1);
        if (killed) begin
            check("no_done_after_kill", dones, 0);
        end else begin
            check("result_count", nres, NN);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_pulse_width", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        load_mats(0);
        run_job(-1, 0, 0, 0, JOB_DONE);

        load_mats(1);
        run_job(-1, 0, 0, 0, JOB_DONE);

        load_mats(2);
        run_job(3, 0, 0, 0, JOB_DONE + 5);

        load_mats(2);
        run_job(-1, 6 * (N + 2) + 2, 0, 0, 0);
        load_mats(2);
        run_job(-1, 0, 0, 0, JOB_DONE);

        load_mats(2);
        run_job(-1, 0, 50, 0, JOB_DONE);

        load_mats(2);
        run_job(-1, 0, 0, 3 * (N + 2), 0);
        load_mats(2);
        run_job(-1, 0, 0, 0, JOB_DONE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
